// File: rtl/sub_borrow_ds_pkg.sv
// Shared types and elaboration helpers for the digit-serial subtractor.
package sub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int unsigned ndig(input int unsigned width, input int unsigned digit);
        return width / digit;
    endfunction

    // A single-digit configuration still needs a 1-bit counter.
    function automatic int unsigned cnt_w(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/sub_borrow_ds_digit.sv
// Combinational DIGIT-bit subtractor: d = a_d - b_d - bin_d with borrow-out.
module sub_digit #(
    parameter int unsigned DIGIT = 8
) (
    input  logic [DIGIT-1:0] a_d,
    input  logic [DIGIT-1:0] b_d,
    input  logic             bin_d,
    output logic [DIGIT-1:0] d,
    output logic             bout_d
);

    logic [DIGIT:0] sum;

    // Subtraction as a + ~b + ~borrow; the carry-out is the inverted borrow.
    always_comb begin
        sum    = {1'b0, a_d} + {1'b0, ~b_d} + {{DIGIT{1'b0}}, ~bin_d};
        d      = sum[DIGIT-1:0];
        bout_d = ~sum[DIGIT];
    end

endmodule

// File: rtl/sub_borrow_ds.sv
// Digit-serial a - b - bin with valid/ready handshakes on both sides.
module sub_borrow_ds
    import sub_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DIGIT = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf
);

    localparam int unsigned NDIG = ndig(WIDTH, DIGIT);
    localparam int unsigned CW   = cnt_w(NDIG);
    localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             borrow_q, borrow_d;
    logic             bout_q, bout_d;
    logic             ovf_q, ovf_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic [DIGIT-1:0] a_dig, b_dig, d_dig;
    logic             bout_dig;

    always_comb begin
        a_dig = '0;
        b_dig = '0;
        for (int unsigned k = 0; k < NDIG; k++) begin
            if (cnt_q == CW'(k)) begin
                a_dig = a_q[k*DIGIT +: DIGIT];
                b_dig = b_q[k*DIGIT +: DIGIT];
            end
        end
    end

    sub_digit #(.DIGIT(DIGIT)) u_digit (
        .a_d    (a_dig),
        .b_d    (b_dig),
        .bin_d  (borrow_q),
        .d      (d_dig),
        .bout_d (bout_dig)
    );

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        diff_d   = diff_q;
        borrow_d = borrow_q;
        bout_d   = bout_q;
        ovf_d    = ovf_q;
        cnt_d    = cnt_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d      = a;
                    b_d      = b;
                    borrow_d = bin;
                    cnt_d    = '0;
                    state_d  = RUN;
                end
            end
            RUN: begin
                for (int unsigned k = 0; k < NDIG; k++) begin
                    if (cnt_q == CW'(k)) begin
                        diff_d[k*DIGIT +: DIGIT] = d_dig;
                    end
                end
                borrow_d = bout_dig;
                cnt_d    = cnt_q + 1'b1;
                // Flags are taken from the final digit as it is written.
                if (cnt_q == LAST) begin
                    bout_d  = bout_dig;
                    ovf_d   = (a_q[WIDTH-1] != b_q[WIDTH-1]) &&
                              (d_dig[DIGIT-1] != a_q[WIDTH-1]);
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
            bout_q   <= 1'b0;
            ovf_q    <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            diff_q   <= diff_d;
            borrow_q <= borrow_d;
            bout_q   <= bout_d;
            ovf_q    <= ovf_d;
            cnt_q    <= cnt_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign diff      = diff_q;
    assign bout      = bout_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_sub_borrow_ds.sv
// Scoreboard bench for sub_borrow_ds against an arithmetic reference model.
module tb_sub_borrow_ds;

    localparam int unsigned NDIG = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        bin = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] diff;
    logic        bout;
    logic        ovf;

    sub_borrow_ds #(.WIDTH(32), .DIGIT(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .bin       (bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .bout      (bout),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] diff;
        logic        bout;
        logic        ovf;
        int          acc;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   rdy_mode = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, req, $time);
        end
    endtask

    // Reference: plain wide-integer arithmetic on the operands.
    function automatic exp_t model(input logic [31:0] av, input logic [31:0] bv, input logic bv_in);
        exp_t        e;
        logic [32:0] full;
        longint      s;
        full   = {1'b0, av} - {1'b0, bv} - {32'd0, bv_in};
        s      = longint'($signed(av)) - longint'($signed(bv)) - longint'(bv_in);
        e.diff = full[31:0];
        e.bout = full[32];
        e.ovf  = (s > 64'sd2147483647) || (s < -64'sd2147483648);
        e.acc  = 0;
        return e;
    endfunction

    initial begin
        forever begin
            @(posedge clk);
            #2;
            case (rdy_mode)
                0: out_ready = 1'b1;
                1: out_ready = 1'($urandom_range(0, 1));
                default: out_ready = 1'b0;
            endcase
        end
    end

    // Monitor: latency, handshake ordering, hold stability and result compare.
    logic        prev_ov = 1'b0;
    logic        hold_pend = 1'b0;
    logic [31:0] h_diff;
    logic        h_bout, h_ovf;
    exp_t        e_m;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_ov   = 1'b0;
            hold_pend = 1'b0;
        end else begin
            if (out_valid && !prev_ov && exp_q.size() > 0)
                chk("latency", 64'(cyc - exp_q[0].acc), 64'(NDIG));
            if (hold_pend) begin
                chk("hold_valid", 64'(out_valid), 64'd1);
                chk("hold_diff", 64'(diff), 64'(h_diff));
                chk("hold_flags", 64'({bout, ovf}), 64'({h_bout, h_ovf}));
            end
            if (out_valid) chk("in_ready_busy", 64'(in_ready), 64'd0);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_out", 64'd1, 64'd0);
                end else begin
                    e_m = exp_q.pop_front();
                    chk("diff", 64'(diff), 64'(e_m.diff));
                    chk("bout", 64'(bout), 64'(e_m.bout));
                    chk("ovf", 64'(ovf), 64'(e_m.ovf));
                end
            end
            prev_ov   = out_valid;
            hold_pend = out_valid && !out_ready;
            h_diff    = diff;
            h_bout    = bout;
            h_ovf     = ovf;
        end
    end

    // Called 1 time unit after a rising edge; returns 1 time unit after the accept edge.
    task automatic issue(input logic [31:0] av, input logic [31:0] bv, input logic bv_in);
        exp_t e;
        int   n;
        n = 0;
        while (!in_ready && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) begin
            chk("accept_timeout", 64'd1, 64'd0);
            return;
        end
        a = av; b = bv; bin = bv_in; in_valid = 1'b1;
        @(posedge clk); #1;
        e     = model(av, bv, bv_in);
        e.acc = cyc;
        exp_q.push_back(e);
        in_valid = 1'b0;
        a = $urandom; b = $urandom; bin = 1'($urandom);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || out_valid) && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        chk("drain", 64'(exp_q.size()), 64'd0);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'h0000_0000;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_diff", 64'(diff), 64'd0);
        chk("rst_flags", 64'({bout, ovf}), 64'd0);

        rdy_mode = 0;
        issue(32'h0000_0005, 32'h0000_0003, 1'b0);
        for (int i = 0; i < NDIG; i++) begin
            chk("in_ready_run", 64'(in_ready), 64'd0);
            @(posedge clk); #1;
        end
        drain();

        issue(32'h0000_0000, 32'h0000_0001, 1'b0);
        issue(32'h8000_0000, 32'h0000_0001, 1'b0);
        issue(32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        issue(32'h0000_0100, 32'h0000_00FF, 1'b1);
        issue(32'h0000_0000, 32'hFFFF_FFFF, 1'b1);
        issue(32'h1234_5678, 32'h1234_5678, 1'b0);
        drain();

        // Backpressure: hold the result and offer a second operand that must be ignored.
        rdy_mode = 2;
        issue(32'hDEAD_BEEF, 32'h1234_5678, 1'b1);
        for (int n = 0; n < 50 && !out_valid; n++) begin
            @(posedge clk); #1;
        end
        chk("bp_valid_seen", 64'(out_valid), 64'd1);
        a = 32'h5555_5555; b = 32'h1111_1111; bin = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("bp_in_ready", 64'(in_ready), 64'd0);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        rdy_mode = 0;
        @(posedge clk); #3;
        chk("bp_release_valid", 64'(out_valid), 64'd0);
        chk("bp_release_ready", 64'(in_ready), 64'd1);
        #(-2+2);
        issue(32'h0000_0010, 32'h0000_0020, 1'b0);
        drain();

        // Reset during the second RUN cycle discards the operation.
        issue(32'hAAAA_AAAA, 32'h5555_5555, 1'b1);
        @(posedge clk); #1;
        rst_n = 1'b0;
        void'(exp_q.pop_back());
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("abort_out_valid", 64'(out_valid), 64'd0);
        chk("abort_in_ready", 64'(in_ready), 64'd1);
        chk("abort_diff", 64'(diff), 64'd0);
        for (int i = 0; i < NDIG + 2; i++) begin
            @(posedge clk); #1;
            chk("abort_silent", 64'(out_valid), 64'd0);
        end
        issue(32'h0000_0100, 32'h0000_0001, 1'b0);
        drain();

        rdy_mode = 1;
        for (int i = 0; i < 40; i++) begin
            issue(pick(), pick(), 1'($urandom));
        end
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/sub_borrow_ds.md
Name: sub_borrow_ds

Overview:
- Digit-serial subtractor, the inverse-direction companion to the datapath's ripple-carry adders.
- Computes diff = a - b - bin over WIDTH bits, DIGIT bits per cycle, with a borrow chain held in a register between digits.
- Sits behind a valid/ready producer and in front of a valid/ready consumer, trading latency for area on wide operands.

Parameters:
- WIDTH, 32, operand/result width in bits; must be an integer multiple of DIGIT.
- DIGIT, 8, bits processed per cycle (borrow ripples combinationally within a digit).

Ports:
- clk  input  1  sole clock, rising edge.
- rst_n  input  1  synchronous active-low reset.
- in_valid  input  1  operands valid.
- in_ready  output  1  block accepts operands.
- a  input  WIDTH  minuend.
- b  input  WIDTH  subtrahend.
- bin  input  1  borrow-in.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- diff  output  WIDTH  a - b - bin modulo 2^WIDTH.
- bout  output  1  borrow-out: 1 iff unsigned a < b + bin.
- ovf  output  1  two's-complement signed overflow.

Behaviour:
- Clock and reset: one clock clk; reset is synchronous and active-low (rst_n), sampled on the rising edge of clk.
- Reset state and values: state=IDLE, out_valid=0, diff=0, bout=0, ovf=0, borrow register=0, digit counter=0. in_ready is decoded from state, so it reads 1 after reset.
- FSM states are IDLE, RUN and DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready: latch a, b and bin; set the borrow register to bin; set the digit index to 0; go to RUN.
- RUN:
  - in_ready=0.
  - Each cycle, digit k (bits k*DIGIT +: DIGIT) computes d = a_k - b_k - borrow.
  - Write d into diff bits k*DIGIT +: DIGIT; the borrow register takes the digit borrow-out.
  - The counter increments. After digit NDIG-1 go to DONE, where NDIG = WIDTH/DIGIT.
- Digit arithmetic: d = a_k + ~b_k + ~borrow (DIGIT+1-bit sum); borrow-out = ~sum[DIGIT].
- Latency: out_valid rises NDIG clock edges after the accept edge (4 for defaults).
- DONE:
  - out_valid=1; bout = final borrow register.
  - ovf = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]).
  - diff, bout and ovf are held stable while out_valid=1 && out_ready=0 (backpressure of any length).
  - On out_ready: out_valid drops next cycle; go to IDLE.
- Throughput: one operation per NDIG+2 cycles minimum. in_ready is never asserted in RUN or DONE, and in_ready has no combinational path from out_ready.
- Outputs keep their last values in IDLE and RUN; only out_valid qualifies them. Partial diff bits change during RUN.
- in_valid while in_ready=0 is ignored. Operands are sampled only on the accept edge, so input changes during RUN have no effect.
- Reset asserted in any state, including mid-RUN: the next edge forces the reset values and the in-flight operation is discarded with no output.
- Edge cases:
  - a=b, bin=0 gives diff=0, bout=0.
  - a=0, b=2^WIDTH-1, bin=1 gives diff=0, bout=1 (maximum borrow wrap-around).
- NDIG=1 (DIGIT=WIDTH) is legal: a single RUN cycle.

Decomposition:
- Shared package (sub_pkg):
  - State enum {IDLE, RUN, DONE}.
  - Function/localparam computing NDIG.
  - Counter width $clog2(NDIG) with a minimum of 1.
- One natural sub-module: sub_digit, a combinational DIGIT-bit borrow-ripple subtractor with ports a_d, b_d, bin_d, d, bout_d.
  - The top holds the FSM, operand/result registers, borrow register and counter.

Test Plan:
- a=0x00000005, b=0x00000003, bin=0, out_ready=1 -> diff=0x00000002, bout=0, ovf=0; out_valid exactly 4 cycles after accept; in_ready=0 throughout RUN/DONE.
- a=0x00000000, b=0x00000001, bin=0 -> diff=0xFFFFFFFF, bout=1, ovf=0.
- a=0x80000000, b=0x00000001, bin=0 -> diff=0x7FFFFFFF, bout=0, ovf=1; and a=0x7FFFFFFF, b=0xFFFFFFFF -> diff=0x80000000, bout=1, ovf=1.
- Cross-digit borrow: a=0x00000100, b=0x000000FF, bin=1 -> diff=0x00000000, bout=0; and a=0, b=0xFFFFFFFF, bin=1 -> diff=0, bout=1.
- Backpressure: out_ready=0 for 5 cycles after out_valid -> diff/bout/ovf/out_valid constant, a second in_valid is not accepted; out_ready=1 -> IDLE, the next operands are accepted on the following cycle.
- rst_n=0 for one cycle during the second RUN cycle -> next cycle out_valid=0, in_ready=1, diff=0; no result is ever emitted for the aborted operation; a fresh operation then completes correctly.
